// File: rtl/fpu_mult_host_seq.sv
// fpu_mult_host_seq: sequences operand pairs through the FP multiplier handshake, with a watchdog abort for a hung multiplier
module fpu_mult_host_seq #(
  parameter int W       = 32,
  parameter int TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_o,
  output logic         res_timeout_o,
  output logic [W-1:0] Data_MX_o,
  output logic [W-1:0] Data_MY_o,
  output logic         beg_FSM_o,
  output logic         ack_FSM_o,
  output logic         mult_rst_o,
  input  logic         ready_i,
  input  logic [W-1:0] result_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, GUARD, ABORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] res_q, res_d, mx_q, mx_d, my_q, my_d;
  logic vld_q, vld_d, to_q, to_d, xfer;
  assign req_ready_o   = (state_q == IDLE) & ~vld_q;
  assign xfer          = req_valid_i & req_ready_o;
  assign res_valid_o   = vld_q;
  assign res_o         = res_q;
  assign res_timeout_o = to_q;
  assign Data_MX_o     = mx_q;
  assign Data_MY_o     = my_q;
  assign beg_FSM_o     = state_q == ISSUE;
  assign ack_FSM_o     = state_q == ACK;
  assign mult_rst_o    = ~rst | (state_q == ABORT);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    to_d    = to_q;
    vld_d   = vld_q & ~res_ready_i;
    mx_d    = xfer ? op_a_i : mx_q;
    my_d    = xfer ? op_b_i : my_q;
    case (state_q)
      IDLE:  state_d = xfer ? ISSUE : IDLE;
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // a result arriving on the last permitted cycle still beats the abort
        if (ready_i) begin
          res_d   = result_i;
          to_d    = 1'b0;
          state_d = ACK;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ABORT;
        end
      end
      ACK: begin
        vld_d   = 1'b1;
        state_d = GUARD;
      end
      GUARD: state_d = IDLE;
      ABORT: begin
        res_d   = '0;
        to_d    = 1'b1;
        vld_d   = 1'b1;
        state_d = GUARD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_fpu_mult_host_seq.sv
// tb_fpu_mult_host_seq: drives the sequencer against a cycle-counting multiplier model and checks results, pulses and timing
module tb_fpu_mult_host_seq;
  localparam int W = 32;
  localparam int TIMEOUT = 63;
  logic clk = 0, rst = 0;
  logic req_valid_i = 0, req_ready_o, res_valid_o, res_ready_i = 0, res_timeout_o;
  logic [W-1:0] op_a_i = 0, op_b_i = 0, res_o, Data_MX_o, Data_MY_o, result_i = 0;
  logic beg_FSM_o, ack_FSM_o, mult_rst_o, ready_i = 0;
  int nvec = 0, nerr = 0, n_beg = 0, n_ack = 0, n_mrst = 0;

  typedef struct {
    logic [W-1:0] a, b, rv;
    int lat, hold;
  } vec_t;
  vec_t tbl[7];

  fpu_mult_host_seq #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_timeout_o(res_timeout_o), .Data_MX_o(Data_MX_o), .Data_MY_o(Data_MY_o),
    .beg_FSM_o(beg_FSM_o), .ack_FSM_o(ack_FSM_o), .mult_rst_o(mult_rst_o),
    .ready_i(ready_i), .result_i(result_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    n_beg += int'(beg_FSM_o);
    n_ack += int'(ack_FSM_o);
    n_mrst += int'(mult_rst_o & rst);
    if (beg_FSM_o | ack_FSM_o) chk("beg_ack_exclusive", 64'(beg_FSM_o & ack_FSM_o), 0);
  end

  // One operation: the multiplier model raises ready_i lat cycles after beg and holds it until ack/abort.
  // A latency beyond TIMEOUT+1 cycles after beg must end in an abort record.
  task automatic do_op(input logic [W-1:0] a, b, rv, input int lat, hold);
    int c, ack_at, mr_at, b0, a0, m0;
    bit done, exp_to;
    logic [W-1:0] exp_res;
    exp_to = lat > TIMEOUT + 1;
    exp_res = exp_to ? '0 : rv;
    @(negedge clk);
    b0 = n_beg; a0 = n_ack; m0 = n_mrst;
    req_valid_i = 1; op_a_i = a; op_b_i = b;
    c = 0;
    while (!req_ready_o && c < 200) begin @(negedge clk); c++; end
    chk("req_ready_wait", 64'(req_ready_o), 1);
    @(negedge clk);
    req_valid_i = 0; op_a_i = $urandom; op_b_i = $urandom;
    chk("beg_after_transfer", 64'(beg_FSM_o), 1);
    chk("mx_issue", 64'(Data_MX_o), 64'(a));
    chk("my_issue", 64'(Data_MY_o), 64'(b));
    ack_at = -1; mr_at = -1; c = 0; done = 0;
    while (!done && c < 300) begin
      @(negedge clk); c++;
      if (ack_FSM_o) ack_at = c;
      if (mult_rst_o) mr_at = c;
      if (res_valid_o) done = 1;
      else if (ack_at < 0 && mr_at < 0) begin
        chk("mx_stable", 64'(Data_MX_o), 64'(a));
        chk("my_stable", 64'(Data_MY_o), 64'(b));
      end
      ready_i = (c >= lat) && ack_at < 0 && mr_at < 0;
      result_i = ready_i ? rv : $urandom;
    end
    ready_i = 0;
    chk("res_valid_seen", 64'(done), 1);
    chk("res_value", 64'(res_o), 64'(exp_res));
    chk("res_timeout", 64'(res_timeout_o), 64'(exp_to));
    chk("ack_cycle", 64'(ack_at), 64'(exp_to ? -1 : lat + 1));
    chk("mult_rst_cycle", 64'(mr_at), 64'(exp_to ? TIMEOUT + 2 : -1));
    chk("valid_cycle", 64'(c), 64'(exp_to ? TIMEOUT + 3 : lat + 2));
    chk("ack_count", 64'(n_ack - a0), 64'(exp_to ? 0 : 1));
    chk("mult_rst_count", 64'(n_mrst - m0), 64'(exp_to ? 1 : 0));
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1; op_a_i = $urandom; op_b_i = $urandom;
      chk("hold_req_ready", 64'(req_ready_o), 0);
      chk("hold_valid", 64'(res_valid_o), 1);
      chk("hold_res", 64'(res_o), 64'(exp_res));
      @(negedge clk);
    end
    req_valid_i = hold > 0;
    chk("release_req_ready", 64'(req_ready_o), 0);
    res_ready_i = 1;
    @(negedge clk);
    res_ready_i = 0; req_valid_i = 0;
    chk("valid_cleared", 64'(res_valid_o), 0);
    chk("res_holds", 64'(res_o), 64'(exp_res));
    chk("idle_ready", 64'(req_ready_o), 1);
    chk("beg_count", 64'(n_beg - b0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [W-1:0] ra, rb, rr;
    int a0;
    tbl[0] = '{a: 32'h40000000, b: 32'h40400000, rv: 32'h40C00000, lat: 10,   hold: 0};
    tbl[1] = '{a: 32'h3F800000, b: 32'h3F800000, rv: 32'h3F800000, lat: 5,    hold: 20};
    tbl[2] = '{a: 32'h40800000, b: 32'h40800000, rv: 32'h41800000, lat: 1000, hold: 0};
    tbl[3] = '{a: 32'h40000000, b: 32'h40000000, rv: 32'h40800000, lat: 3,    hold: 0};
    tbl[4] = '{a: 32'hC0000000, b: 32'h40400000, rv: 32'hC0C00000, lat: 64,   hold: 0};
    tbl[5] = '{a: 32'h3F000000, b: 32'h3F000000, rv: 32'h3E800000, lat: 65,   hold: 3};
    tbl[6] = '{a: 32'h41200000, b: 32'h41200000, rv: 32'h42C80000, lat: 1,    hold: 0};
    repeat (2) @(negedge clk);
    chk("reset_mult_rst", 64'(mult_rst_o), 1);
    chk("reset_valid", 64'(res_valid_o), 0);
    chk("reset_beg", 64'(beg_FSM_o), 0);
    chk("reset_res", 64'(res_o), 0);
    chk("reset_mx", 64'(Data_MX_o), 0);
    #2 rst = 1;
    #1 chk("post_reset_mult_rst", 64'(mult_rst_o), 0);
    chk("post_reset_req_ready", 64'(req_ready_o), 1);
    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].rv, tbl[i].lat, tbl[i].hold);
    @(negedge clk);
    req_valid_i = 1; op_a_i = 32'h12345678; op_b_i = 32'h9ABCDEF0;
    @(negedge clk);
    req_valid_i = 0;
    a0 = n_ack;
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1 chk("midop_mult_rst", 64'(mult_rst_o), 1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("midop_valid", 64'(res_valid_o), 0);
    chk("midop_timeout", 64'(res_timeout_o), 0);
    chk("midop_beg", 64'(beg_FSM_o), 0);
    chk("midop_ack", 64'(ack_FSM_o), 0);
    chk("midop_mx", 64'(Data_MX_o), 0);
    chk("midop_my", 64'(Data_MY_o), 0);
    chk("midop_res", 64'(res_o), 0);
    chk("midop_req_ready", 64'(req_ready_o), 1);
    chk("midop_mult_rst_release", 64'(mult_rst_o), 0);
    ready_i = 1;
    repeat (5) @(negedge clk);
    ready_i = 0;
    chk("midop_no_ack", 64'(n_ack - a0), 0);
    do_op(32'h40A00000, 32'h40000000, 32'h41200000, 7, 0);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rr = $urandom;
      do_op(ra, rb, rr, int'($urandom_range(4, 30)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
